// File: rtl/pusher_pkg.sv
// Shared definitions for the pusher queue: the width helper, the full-queue policy
// codes and the per-cycle transfer decode record.
package pusher_pkg;

    localparam int MODE_BACKPRESSURE = 0;
    localparam int MODE_DROP_OLDEST  = 1;

    // Smallest n with 2**n >= value, usable in parameter and port expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } xfer_t;

endpackage

// File: rtl/pusher_ptr.sv
// Queue pointer that counts modulo DEPTH, with an increment enable and a
// synchronous clear.
module pusher_ptr
    import pusher_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          incr_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        // NOTE: ptr_d gets a default before any condition so every path assigns it and no latch is inferred.
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (incr_i) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pusher_queue.sv
// Registered FIFO with a selectable full-queue policy: backpressure, or discard
// the oldest entry and pulse dropped.
module pusher_queue
    import pusher_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = MODE_BACKPRESSURE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [clog2(DEPTH+1)-1:0]   count,
    output logic                        dropped
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             dropped_q;
    logic             dropped_d;
    logic             full;
    logic             empty;
    xfer_t            xfer;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // in_ready looks only at occupancy and flush, never at out_ready.
    assign in_ready  = (OVERWRITE == MODE_DROP_OLDEST) ? !flush : (!full && !flush);
    assign out_valid = !empty;

    always_comb begin
        xfer.push = in_valid && in_ready;
        xfer.pop  = out_valid && out_ready && !flush;
        xfer.drop = (OVERWRITE == MODE_DROP_OLDEST) && xfer.push && full && !xfer.pop;
    end

    // A drop overwrites the oldest slot, so count holds while both pointers advance.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (xfer.push && !xfer.pop && !full) begin
            count_d = count_q + 1'b1;
        end else if (xfer.pop && !xfer.push) begin
            count_d = count_q - 1'b1;
        end
    end

    assign dropped_d = xfer.drop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    pusher_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (flush),
        .incr_i  (xfer.pop || xfer.drop),
        .ptr_o   (rd_ptr)
    );

    pusher_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (flush),
        .incr_i  (xfer.push),
        .ptr_o   (wr_ptr)
    );

    // NOTE: storage has no reset; validity is tracked by count, so clearing the array buys nothing.
    always_ff @(posedge clock) begin
        if (xfer.push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data = mem[rd_ptr];
    assign count    = count_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_pusher_queue.sv
// Self-checking bench for pusher_queue: a vector table on the backpressure queue,
// scoreboard sequences on the drop-oldest queue, and a random run on a wide queue.
module tb_pusher_queue;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Instance A: defaults, backpressure.
    logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic       a_in_ready, a_out_valid, a_dropped;
    logic [7:0] a_in_data = '0, a_out_data;
    logic [2:0] a_count;

    // Instance B: DEPTH=4, drop oldest.
    logic       b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic       b_in_ready, b_out_valid, b_dropped;
    logic [7:0] b_in_data = '0, b_out_data;
    logic [2:0] b_count;

    // Instance C: WIDTH=16, DEPTH=8, backpressure.
    logic        c_flush = 0, c_in_valid = 0, c_out_ready = 0;
    logic        c_in_ready, c_out_valid, c_dropped;
    logic [15:0] c_in_data = '0, c_out_data;
    logic [3:0]  c_count;

    pusher_queue u_a (
        .clock(clock), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .dropped(a_dropped)
    );

    pusher_queue #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1)) u_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .dropped(b_dropped)
    );

    pusher_queue #(.WIDTH(16), .DEPTH(8), .OVERWRITE(0)) u_c (
        .clock(clock), .reset(reset), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .count(c_count), .dropped(c_dropped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic fl, logic iv, logic [7:0] d, logic rdy,
                                logic e_ir, logic e_ov, logic [7:0] e_od, logic [2:0] e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.rdy = rdy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    localparam int NV = 17;
    vec_t vecs[NV];

    logic [7:0] ow_q[$];
    logic [7:0] ow_out[$];
    logic       ow_exp_drop = 1'b0;
    int         ow_drops = 0;

    // Drives B for one cycle, checks it against the model, then applies the edge to the model.
    task automatic ow_cycle(input logic v, input logic [7:0] d, input logic r);
        logic popped;
        b_in_valid = v; b_in_data = d; b_out_ready = r; b_flush = 1'b0;
        @(negedge clock);
        check("ow_count", 32'(b_count), 32'(ow_q.size()));
        check("ow_in_ready", 32'(b_in_ready), 32'd1);
        check("ow_out_valid", 32'(b_out_valid), 32'(ow_q.size() != 0));
        check("ow_dropped", 32'(b_dropped), 32'(ow_exp_drop));
        if (b_dropped) ow_drops++;
        popped = 1'b0;
        if (r && ow_q.size() != 0) begin
            check("ow_out_data", 32'(b_out_data), 32'(ow_q[0]));
            ow_out.push_back(ow_q.pop_front());
            popped = 1'b1;
        end
        ow_exp_drop = 1'b0;
        if (v) begin
            if (ow_q.size() == 4 && !popped) begin
                ow_exp_drop = 1'b1;
                void'(ow_q.pop_front());
            end
            ow_q.push_back(d);
        end
        tick();
    endtask

    logic [15:0] rnd_q[$];

    initial begin
        // Backpressure scenario, then flush with a concurrent push and pop.
        vecs[0]  = mk(0, 1, 8'h11, 0, 1, 0, 8'h00, 3'd0);
        vecs[1]  = mk(0, 1, 8'h22, 0, 1, 1, 8'h11, 3'd1);
        vecs[2]  = mk(0, 1, 8'h33, 0, 1, 1, 8'h11, 3'd2);
        vecs[3]  = mk(0, 1, 8'h44, 0, 1, 1, 8'h11, 3'd3);
        vecs[4]  = mk(0, 1, 8'h55, 1, 0, 1, 8'h11, 3'd4);
        vecs[5]  = mk(0, 0, 8'h00, 1, 1, 1, 8'h22, 3'd3);
        vecs[6]  = mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 3'd2);
        vecs[7]  = mk(0, 0, 8'h00, 1, 1, 1, 8'h44, 3'd1);
        vecs[8]  = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0);
        vecs[9]  = mk(0, 1, 8'hA1, 0, 1, 0, 8'h00, 3'd0);
        vecs[10] = mk(0, 1, 8'hA2, 0, 1, 1, 8'hA1, 3'd1);
        vecs[11] = mk(0, 1, 8'hA3, 0, 1, 1, 8'hA1, 3'd2);
        vecs[12] = mk(1, 1, 8'hEE, 1, 0, 1, 8'hA1, 3'd3);
        vecs[13] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0);
        vecs[14] = mk(0, 1, 8'h77, 0, 1, 0, 8'h00, 3'd0);
        vecs[15] = mk(0, 0, 8'h00, 1, 1, 1, 8'h77, 3'd1);
        vecs[16] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0);

        #2;
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_dropped", 32'(b_dropped), 32'd0);
        #10 reset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            a_flush = vecs[i].fl; a_in_valid = vecs[i].iv;
            a_in_data = vecs[i].d; a_out_ready = vecs[i].rdy;
            @(negedge clock);
            check($sformatf("vec%0d_in_ready", i), 32'(a_in_ready), 32'(vecs[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_count", i), 32'(a_count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d_dropped", i), 32'(a_dropped), 32'd0);
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_out_data", i), 32'(a_out_data), 32'(vecs[i].e_od));
            end
            tick();
        end
        a_flush = 0; a_in_valid = 0; a_out_ready = 0;

        // Drop-oldest: six pushes into four slots.
        ow_drops = 0;
        ow_out.delete();
        for (int i = 1; i <= 6; i++) ow_cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 6; i++) ow_cycle(1'b0, 8'h00, 1'b1);
        check("ow_drop_pulses", 32'(ow_drops), 32'd2);
        check("ow_drain_len", 32'(ow_out.size()), 32'd4);
        for (int k = 0; k < 4 && k < ow_out.size(); k++) begin
            check($sformatf("ow_drain%0d", k), 32'(ow_out[k]), 32'(k + 3));
        end

        // Full queue with push and pop together every cycle across several wraps.
        ow_drops = 0;
        for (int i = 0; i < 4; i++) ow_cycle(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            ow_cycle(1'b1, 8'(8'h14 + i), 1'b1);
            check("ow_full_count", 32'(b_count), 32'd4);
        end
        for (int i = 0; i < 5; i++) ow_cycle(1'b0, 8'h00, 1'b1);
        check("ow_full_no_drops", 32'(ow_drops), 32'd0);
        b_in_valid = 0; b_out_ready = 0;

        // Asynchronous reset between edges with two entries held.
        a_in_valid = 1'b1; a_in_data = 8'h5A;
        tick();
        a_in_data = 8'h5B;
        tick();
        a_in_valid = 1'b0;
        #1;
        check("pre_reset_count", 32'(a_count), 32'd2);
        #1 reset = 1'b0;
        #1;
        check("async_count", 32'(a_count), 32'd0);
        check("async_out_valid", 32'(a_out_valid), 32'd0);
        check("async_in_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1; a_in_data = 8'hA5;
        @(posedge clock);
        #2;
        check("held_reset_count", 32'(a_count), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        a_in_valid = 1'b0;
        @(negedge clock);
        check("post_reset_count", 32'(a_count), 32'd1);
        check("post_reset_out_valid", 32'(a_out_valid), 32'd1);
        check("post_reset_out_data", 32'(a_out_data), 32'h0000_00A5);
        tick();

        // Random traffic on the wide queue against a queue model.
        begin
            int fail_base;
            fail_base = fails;
            rnd_q.delete();
            for (int i = 0; i < 10000; i++) begin
                logic model_ready;
                c_in_valid  = ($urandom_range(0, 99) < 60);
                c_in_data   = 16'($urandom);
                c_out_ready = ((i / 1000) % 2 == 1) ? ($urandom_range(0, 99) < 30)
                                                    : ($urandom_range(0, 99) < 70);
                c_flush     = ($urandom_range(0, 199) == 0);
                @(negedge clock);
                model_ready = (rnd_q.size() != 8) && !c_flush;
                check("rnd_count", 32'(c_count), 32'(rnd_q.size()));
                check("rnd_out_valid", 32'(c_out_valid), 32'(rnd_q.size() != 0));
                check("rnd_in_ready", 32'(c_in_ready), 32'(model_ready));
                check("rnd_dropped", 32'(c_dropped), 32'd0);
                if (c_flush) begin
                    rnd_q.delete();
                end else begin
                    if (c_out_ready && rnd_q.size() != 0) begin
                        check("rnd_out_data", 32'(c_out_data), 32'(rnd_q[0]));
                        void'(rnd_q.pop_front());
                    end
                    if (c_in_valid && model_ready) rnd_q.push_back(c_in_data);
                end
                tick();
                if (fails > fail_base + 20) break;
            end
            c_in_valid = 0; c_out_ready = 0; c_flush = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pusher_queue.md
PUSHER_QUEUE -- requirements
Module: pusher_queue

Interface
REQ-001 Parameter: WIDTH, default 8, data bit width (>=1).
REQ-002 Parameter: DEPTH, default 4, entry count (power of two, >=2).
REQ-003 Parameter: OVERWRITE, default 0, full-queue policy (0 = backpressure, 1 = drop oldest).
REQ-004 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: flush  input  1  synchronous clear of all entries.
REQ-007 Port: in_valid  input  1  producer offers in_data.
REQ-008 Port: in_ready  output  1  queue accepts in_data this cycle.
REQ-009 Port: in_data  input  WIDTH  pushed item.
REQ-010 Port: out_valid  output  1  out_data holds the oldest entry.
REQ-011 Port: out_ready  input  1  consumer takes out_data this cycle.
REQ-012 Port: out_data  output  WIDTH  oldest entry.
REQ-013 Port: count  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-014 Port: dropped  output  1  one-cycle pulse when an entry is discarded under OVERWRITE=1.

Function
REQ-015 Push SHALL occur on a rising edge with in_valid && in_ready; pop SHALL occur with out_valid && out_ready.
REQ-016 Order SHALL be strict FIFO; an item pushed at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N (no same-cycle fall-through).
REQ-017 out_valid SHALL equal (count != 0); out_data SHALL be don't-care when out_valid=0.
REQ-018 OVERWRITE=0: in_ready SHALL equal (count != DEPTH) && !flush; in_ready SHALL NOT depend combinationally on out_ready.
REQ-019 OVERWRITE=1: in_ready SHALL equal !flush; a push while count==DEPTH and no pop SHALL discard the oldest entry, keep count at DEPTH, and assert dropped for exactly one cycle.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and SHALL NOT assert dropped, including at count==DEPTH.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-022 flush=1 SHALL set count to 0, reset both pointers, and ignore any push or pop in that cycle; out_valid SHALL be 0 in the following cycle.
REQ-023 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow below 0.
REQ-024 Storage contents SHALL NOT be cleared by flush or reset; only the pointers and count are cleared.

Reset
REQ-025 reset low SHALL immediately clear the pointers and count and force out_valid=0 and dropped=0, independent of clock.
REQ-026 While reset is low, in_ready SHALL be 1 (occupancy is 0); the first push SHALL be taken on the first rising edge after reset deasserts.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; after release the queue SHALL behave as empty.

Structure
REQ-028 A shared package pusher_pkg SHALL hold the count-width function clog2 and the OVERWRITE mode constants (MODE_BACKPRESSURE=0, MODE_DROP_OLDEST=1).
REQ-029 A sub-module pusher_ptr (wrapping DEPTH-modulo pointer with increment enable and synchronous clear) SHALL be instantiated twice, once for the read pointer and once for the write pointer.
REQ-030 Storage SHALL be a register array of DEPTH x WIDTH with a combinational read at the read pointer.

Verification
REQ-031 Defaults, OVERWRITE=0: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4 and in_ready=0; then push 0x55 while pop -> outputs 0x11,0x22,0x33,0x44 in order and 0x55 is not accepted.
REQ-032 Full with simultaneous push/pop: count=4, in_valid=1 and out_ready=1 for 10 cycles with incrementing data -> count stays 4, no gaps, order preserved across 2+ pointer wraps.
REQ-033 OVERWRITE=1, DEPTH=4: push 0x01..0x06 with out_ready=0 -> dropped pulses twice, then drain yields 0x03,0x04,0x05,0x06.
REQ-034 Flush: count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0; the in_data offered in the flush cycle is never output.
REQ-035 Async reset: drop reset between clock edges at count=2 -> count=0 and out_valid=0 before the next edge; after release, push 0xA5 -> out_data=0xA5 one cycle later.
REQ-036 WIDTH=16, DEPTH=8, random valid/ready: scoreboard comparison shows zero mismatches over 10000 cycles, and count always matches the model.
